// File: rtl/cla_pkg.sv
// Shared types and defaults for the pipelined carry-lookahead adder/subtractor.
package cla_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_GROUP = 4;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_ADC = 2'd1,
    OP_SUB = 2'd2,
    OP_SBB = 2'd3
  } op_e;

  typedef struct packed {
    logic cout;
    logic ovf;
    logic zero;
  } flags_t;

  // SUB forces the +1 of two's complement; ADC/SBB take the external carry.
  function automatic logic carry_in_for(input op_e op, input logic cin);
    logic c;
    case (op)
      OP_ADD:  c = 1'b0;
      OP_ADC:  c = cin;
      OP_SUB:  c = 1'b1;
      OP_SBB:  c = cin;
      default: c = 1'b0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/cla_group.sv
// One GROUP-bit lookahead block: every internal carry is a flat sum-of-products
// of the group carry-in, so there is no ripple path inside the group.
module cla_group #(
  parameter int GROUP = 4
) (
  input  logic [GROUP-1:0] a_i,
  input  logic [GROUP-1:0] b_i,
  input  logic             cin_i,
  output logic [GROUP-1:0] sum_o,
  output logic             cout_o,
  output logic             cmsb_o
);

  logic [GROUP-1:0] p;
  logic [GROUP-1:0] g;
  logic [GROUP:0]   c;

  assign p = a_i ^ b_i;
  assign g = a_i & b_i;

  // c[i] = (cin & p[0..i-1]) | OR_j (g[j] & p[j+1..i-1])
  function automatic logic lookahead(input logic [GROUP-1:0] p_v,
                                     input logic [GROUP-1:0] g_v,
                                     input logic c_in,
                                     input int i);
    logic res;
    logic term;
    res = c_in;
    for (int j = 0; j < i; j++) begin
      res = res & p_v[j];
    end
    for (int j = 0; j < i; j++) begin
      term = g_v[j];
      for (int k = j + 1; k < i; k++) begin
        term = term & p_v[k];
      end
      res = res | term;
    end
    return res;
  endfunction

  generate
    for (genvar gi = 0; gi <= GROUP; gi++) begin : g_carry
      assign c[gi] = lookahead(p, g, cin_i, gi);
    end
  endgenerate

  assign sum_o  = p ^ c[GROUP-1:0];
  assign cout_o = c[GROUP];
  assign cmsb_o = c[GROUP-1];

endmodule

// File: rtl/pipelined_cla_addsub.sv
// Pipelined CLA add/subtract: group k is resolved in stage k from a registered
// carry, with triangular skew (operands) and deskew (results) register banks.
module pipelined_cla_addsub
  import cla_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int GROUP = DEFAULT_GROUP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NUM_GROUPS = WIDTH / GROUP;
  localparam int N          = NUM_GROUPS;
  localparam int SKEW_BITS  = GROUP * N * (N + 1) / 2;
  localparam int DESK_BITS  = (N > 1) ? GROUP * N * (N - 1) / 2 : 1;

  // Rank k of the skew bank holds operand bits [WIDTH-1 : k*GROUP].
  function automatic int skew_off(input int k);
    return GROUP * (k * N - k * (k - 1) / 2);
  endfunction

  // Rank k of the deskew bank holds result bits [k*GROUP-1 : 0].
  function automatic int desk_off(input int k);
    return GROUP * k * (k - 1) / 2;
  endfunction

  logic             en;
  op_e              op_s;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  logic [SKEW_BITS-1:0] a_skew_q, a_skew_d;
  logic [SKEW_BITS-1:0] b_skew_q, b_skew_d;
  logic [DESK_BITS-1:0] desk_q, desk_d;
  logic [N-1:0]         carry_q, carry_d;
  logic [N-1:0]         valid_q, valid_d;

  logic [N-1:0][GROUP-1:0] grp_sum;
  logic [N-1:0]            grp_cout;
  logic                    cmsb_last;

  logic [WIDTH-1:0] sum_q, sum_d;
  flags_t           flags_q, flags_d;
  logic             out_valid_q;

  assign en       = !out_valid_q || out_ready;
  assign in_ready = en;

  assign op_s  = op_e'(op);
  assign b_eff = op[1] ? ~b : b;
  assign c0    = carry_in_for(op_s, cin);

  assign a_skew_d[0 +: WIDTH] = a;
  assign b_skew_d[0 +: WIDTH] = b_eff;
  assign carry_d[0]           = c0;
  assign valid_d[0]           = in_valid;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_stage
      if (gi < N - 1) begin : g_mid
        logic cmsb_unused;

        cla_group #(.GROUP(GROUP)) u_grp (
          .a_i    (a_skew_q[skew_off(gi) +: GROUP]),
          .b_i    (b_skew_q[skew_off(gi) +: GROUP]),
          .cin_i  (carry_q[gi]),
          .sum_o  (grp_sum[gi]),
          .cout_o (grp_cout[gi]),
          .cmsb_o (cmsb_unused)
        );

        assign a_skew_d[skew_off(gi + 1) +: (N - gi - 1) * GROUP] =
          a_skew_q[skew_off(gi) + GROUP +: (N - gi - 1) * GROUP];
        assign b_skew_d[skew_off(gi + 1) +: (N - gi - 1) * GROUP] =
          b_skew_q[skew_off(gi) + GROUP +: (N - gi - 1) * GROUP];
        assign carry_d[gi + 1] = grp_cout[gi];
        assign valid_d[gi + 1] = valid_q[gi];

        if (gi == 0) begin : g_desk_first
          assign desk_d[desk_off(1) +: GROUP] = grp_sum[0];
        end else begin : g_desk_grow
          assign desk_d[desk_off(gi + 1) +: (gi + 1) * GROUP] =
            {grp_sum[gi], desk_q[desk_off(gi) +: gi * GROUP]};
        end
      end else begin : g_last
        // Only the top group's MSB carry feeds the signed-overflow flag.
        cla_group #(.GROUP(GROUP)) u_grp (
          .a_i    (a_skew_q[skew_off(gi) +: GROUP]),
          .b_i    (b_skew_q[skew_off(gi) +: GROUP]),
          .cin_i  (carry_q[gi]),
          .sum_o  (grp_sum[gi]),
          .cout_o (grp_cout[gi]),
          .cmsb_o (cmsb_last)
        );
      end
    end

    if (N > 1) begin : g_out_multi
      assign sum_d = {grp_sum[N-1], desk_q[desk_off(N - 1) +: (N - 1) * GROUP]};
    end else begin : g_out_single
      assign sum_d  = grp_sum[0];
      assign desk_d = '0;
    end
  endgenerate

  assign flags_d.cout = grp_cout[N-1];
  assign flags_d.ovf  = grp_cout[N-1] ^ cmsb_last;
  assign flags_d.zero = (sum_d == '0);

  // A single enable freezes every rank, so stalls hold both data and bubbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_skew_q    <= '0;
      b_skew_q    <= '0;
      desk_q      <= '0;
      carry_q     <= '0;
      valid_q     <= '0;
      sum_q       <= '0;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
    end else if (en) begin
      a_skew_q    <= a_skew_d;
      b_skew_q    <= b_skew_d;
      desk_q      <= desk_d;
      carry_q     <= carry_d;
      valid_q     <= valid_d;
      sum_q       <= sum_d;
      flags_q     <= flags_d;
      out_valid_q <= valid_q[N-1];
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = flags_q.cout;
  assign ovf       = flags_q.ovf;
  assign zero      = flags_q.zero;

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Directed bench for pipelined_cla_addsub at default parameters (16-bit, 4-bit groups).
module tb_pipelined_cla_addsub;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a_s = '0;
  logic [15:0] b_s = '0;
  logic        cin_s = 1'b0;
  logic [1:0]  op_s = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] sum_s;
  logic        cout_s;
  logic        ovf_s;
  logic        zero_s;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } exp_t;

  pipelined_cla_addsub dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a_s),
    .b         (b_s),
    .cin       (cin_s),
    .op        (op_s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum_s),
    .cout      (cout_s),
    .ovf       (ovf_s),
    .zero      (zero_s)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: 17-bit add, overflow from operand/result sign relationship.
  function automatic exp_t model(input logic [1:0] op, input logic [15:0] a,
                                 input logic [15:0] b, input logic c);
    exp_t        e;
    logic [15:0] be;
    logic        c0;
    logic [16:0] full;
    be   = op[1] ? ~b : b;
    c0   = (op == 2'd0) ? 1'b0 : (op == 2'd2) ? 1'b1 : c;
    full = {1'b0, a} + {1'b0, be} + {16'd0, c0};
    e.sum  = full[15:0];
    e.cout = full[16];
    e.ovf  = (a[15] == be[15]) && (full[15] != a[15]);
    e.zero = (full[15:0] == 16'd0);
    return e;
  endfunction

  // Drives one beat with out_ready=1 and returns edges from acceptance to out_valid.
  task automatic run_beat(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic c, output int lat);
    @(posedge clk); #1;
    op_s = op; a_s = a; b_s = b; cin_s = c; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = -1;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #2;
    n_cmp++;
    if ({out_valid, sum_s, cout_s, ovf_s, zero_s} !== 20'd0) begin
      $display("FAIL reset_outputs: got ov=%b sum=%h c=%b v=%b z=%b required all zero",
               out_valid, sum_s, cout_s, ovf_s, zero_s);
      n_bad++;
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      $display("FAIL reset_in_ready: got %b required 1", in_ready);
      n_bad++;
    end
    @(posedge clk); @(posedge clk); @(negedge clk);
    rst = 1'b0;
    $display("test_reset: outputs idle in reset");
  endtask

  task automatic test_add_flags();
    int lat;
    run_beat(2'd0, 16'hFFFF, 16'h0001, 1'b0, lat);
    n_cmp++;
    if (lat !== 4) begin
      $display("FAIL add_latency: got %0d required 4", lat); n_bad++;
    end
    n_cmp++;
    if ({sum_s, cout_s, ovf_s, zero_s} !== {16'h0000, 1'b1, 1'b0, 1'b1}) begin
      $display("FAIL add_ffff_1: got %h c=%b v=%b z=%b required 0000 c=1 v=0 z=1",
               sum_s, cout_s, ovf_s, zero_s); n_bad++;
    end
    $display("ADD FFFF+0001 -> %h c=%b v=%b z=%b lat=%0d", sum_s, cout_s, ovf_s, zero_s, lat);
    run_beat(2'd0, 16'h7FFF, 16'h0001, 1'b0, lat);
    n_cmp++;
    if ({sum_s, cout_s, ovf_s, zero_s} !== {16'h8000, 1'b0, 1'b1, 1'b0}) begin
      $display("FAIL add_7fff_1: got %h c=%b v=%b z=%b required 8000 c=0 v=1 z=0",
               sum_s, cout_s, ovf_s, zero_s); n_bad++;
    end
    $display("ADD 7FFF+0001 -> %h c=%b v=%b z=%b", sum_s, cout_s, ovf_s, zero_s);
    run_beat(2'd0, 16'h1234, 16'h0001, 1'b1, lat);
    n_cmp++;
    if ({sum_s, cout_s, ovf_s, zero_s} !== {16'h1235, 1'b0, 1'b0, 1'b0}) begin
      $display("FAIL add_ignores_cin: got %h c=%b v=%b z=%b required 1235 c=0 v=0 z=0",
               sum_s, cout_s, ovf_s, zero_s); n_bad++;
    end
    $display("ADD 1234+0001 cin=1 -> %h", sum_s);
  endtask

  task automatic test_sub_sbb();
    int lat;
    run_beat(2'd2, 16'h0005, 16'h0007, 1'b0, lat);
    n_cmp++;
    if ({sum_s, cout_s, ovf_s, zero_s} !== {16'hFFFE, 1'b0, 1'b0, 1'b0}) begin
      $display("FAIL sub_5_7: got %h c=%b v=%b z=%b required FFFE c=0 v=0 z=0",
               sum_s, cout_s, ovf_s, zero_s); n_bad++;
    end
    $display("SUB 0005-0007 -> %h c=%b v=%b", sum_s, cout_s, ovf_s);
    run_beat(2'd3, 16'h0005, 16'h0003, 1'b1, lat);
    n_cmp++;
    if ({sum_s, cout_s, ovf_s, zero_s} !== {16'h0002, 1'b1, 1'b0, 1'b0}) begin
      $display("FAIL sbb_5_3_c1: got %h c=%b v=%b z=%b required 0002 c=1 v=0 z=0",
               sum_s, cout_s, ovf_s, zero_s); n_bad++;
    end
    $display("SBB 0005-0003 cin=1 -> %h c=%b", sum_s, cout_s);
    run_beat(2'd3, 16'h0005, 16'h0003, 1'b0, lat);
    n_cmp++;
    if ({sum_s, cout_s, ovf_s, zero_s} !== {16'h0001, 1'b1, 1'b0, 1'b0}) begin
      $display("FAIL sbb_5_3_c0: got %h c=%b v=%b z=%b required 0001 c=1 v=0 z=0",
               sum_s, cout_s, ovf_s, zero_s); n_bad++;
    end
    $display("SBB 0005-0003 cin=0 -> %h c=%b", sum_s, cout_s);
    run_beat(2'd2, 16'h8000, 16'h0001, 1'b0, lat);
    n_cmp++;
    if ({sum_s, cout_s, ovf_s, zero_s} !== {16'h7FFF, 1'b1, 1'b1, 1'b0}) begin
      $display("FAIL sub_8000_1: got %h c=%b v=%b z=%b required 7FFF c=1 v=1 z=0",
               sum_s, cout_s, ovf_s, zero_s); n_bad++;
    end
    $display("SUB 8000-0001 -> %h c=%b v=%b", sum_s, cout_s, ovf_s);
  endtask

  task automatic test_adc_carry_chain();
    int lat;
    run_beat(2'd1, 16'h0FFF, 16'h0000, 1'b1, lat);
    n_cmp++;
    if ({sum_s, cout_s, ovf_s, zero_s} !== {16'h1000, 1'b0, 1'b0, 1'b0}) begin
      $display("FAIL adc_0fff_c1: got %h c=%b v=%b z=%b required 1000 c=0 v=0 z=0",
               sum_s, cout_s, ovf_s, zero_s); n_bad++;
    end
    $display("ADC 0FFF+0000 cin=1 -> %h", sum_s);
    run_beat(2'd1, 16'hFFFF, 16'h0000, 1'b1, lat);
    n_cmp++;
    if ({sum_s, cout_s, ovf_s, zero_s} !== {16'h0000, 1'b1, 1'b0, 1'b1}) begin
      $display("FAIL adc_ffff_c1: got %h c=%b v=%b z=%b required 0000 c=1 v=0 z=1",
               sum_s, cout_s, ovf_s, zero_s); n_bad++;
    end
    $display("ADC FFFF+0000 cin=1 -> %h c=%b z=%b", sum_s, cout_s, zero_s);
    run_beat(2'd1, 16'h7FFF, 16'h0000, 1'b0, lat);
    n_cmp++;
    if ({sum_s, cout_s, ovf_s, zero_s} !== {16'h7FFF, 1'b0, 1'b0, 1'b0}) begin
      $display("FAIL adc_7fff_c0: got %h c=%b v=%b z=%b required 7FFF c=0 v=0 z=0",
               sum_s, cout_s, ovf_s, zero_s); n_bad++;
    end
    $display("ADC 7FFF+0000 cin=0 -> %h", sum_s);
  endtask

  task automatic test_back_to_back_stall();
    logic [15:0] ta [16];
    logic [15:0] tb [16];
    logic [1:0]  top [16];
    logic        tc [16];
    logic [3:0]  pat;
    exp_t        q[$];
    exp_t        e;
    int          sent;
    int          recv;
    int          cyc;
    pat  = 4'b1001;
    sent = 0;
    recv = 0;
    for (int i = 0; i < 16; i++) begin
      ta[i]  = 16'($urandom);
      tb[i]  = 16'($urandom);
      top[i] = 2'($urandom_range(3, 0));
      tc[i]  = 1'($urandom_range(1, 0));
    end
    for (cyc = 0; cyc < 200 && recv < 16; cyc++) begin
      @(posedge clk); #1;
      out_ready = pat[cyc % 4];
      in_valid  = (sent < 16);
      if (sent < 16) begin
        a_s = ta[sent]; b_s = tb[sent]; op_s = top[sent]; cin_s = tc[sent];
      end
      #1;
      n_cmp++;
      if (in_ready !== !(out_valid && !out_ready)) begin
        $display("FAIL stream_in_ready cyc %0d: got %b with out_valid=%b out_ready=%b",
                 cyc, in_ready, out_valid, out_ready); n_bad++;
      end
      if (out_valid) begin
        if (q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL stream_extra cyc %0d: got result %h required no output", cyc, sum_s);
        end else begin
          e = q[0];
          n_cmp++;
          if ({sum_s, cout_s, ovf_s, zero_s} !== {e.sum, e.cout, e.ovf, e.zero}) begin
            $display("FAIL stream_beat %0d: got %h c=%b v=%b z=%b required %h c=%b v=%b z=%b",
                     recv, sum_s, cout_s, ovf_s, zero_s, e.sum, e.cout, e.ovf, e.zero);
            n_bad++;
          end
          if (out_ready) begin
            $display("stream beat %0d out: sum=%h c=%b v=%b z=%b", recv, sum_s, cout_s, ovf_s, zero_s);
            void'(q.pop_front());
            recv++;
          end
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(model(top[sent], ta[sent], tb[sent], tc[sent]));
        sent++;
      end
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n_cmp++;
    if (recv !== 16 || sent !== 16) begin
      $display("FAIL stream_count: got sent=%0d received=%0d required 16/16", sent, recv);
      n_bad++;
    end
  endtask

  task automatic test_reset_midflight();
    int lat;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      op_s = 2'd0; a_s = 16'(i + 1); b_s = 16'(i + 1); cin_s = 1'b0; in_valid = 1'b1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_cmp++;
    if ({out_valid, sum_s} !== {1'b1, 16'h0002}) begin
      $display("FAIL midflight_pre: got ov=%b sum=%h required ov=1 sum=0002", out_valid, sum_s);
      n_bad++;
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({out_valid, sum_s, cout_s, ovf_s, zero_s} !== 20'd0) begin
      $display("FAIL midflight_async: got ov=%b sum=%h required ov=0 sum=0000", out_valid, sum_s);
      n_bad++;
    end
    $display("reset asserted mid-flight: out_valid=%b sum=%h", out_valid, sum_s);
    @(posedge clk); @(posedge clk); @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (out_valid !== 1'b0) begin
        $display("FAIL midflight_stale cyc %0d: got out_valid=%b sum=%h required 0", i, out_valid, sum_s);
        n_bad++;
      end
    end
    run_beat(2'd0, 16'h0100, 16'h0200, 1'b0, lat);
    n_cmp++;
    if (lat !== 4 || sum_s !== 16'h0300) begin
      $display("FAIL midflight_new: got lat=%0d sum=%h required lat=4 sum=0300", lat, sum_s);
      n_bad++;
    end
    $display("post-reset ADD 0100+0200 -> %h lat=%0d", sum_s, lat);
  endtask

  initial begin
    test_reset();
    test_add_flags();
    test_sub_sbb();
    test_adc_carry_chain();
    test_back_to_back_stall();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
